rhd_acq_sequencer: RTL and testbench

RHD_ACQ_SEQUENCER -- requirements
Module: rhd_acq_sequencer

---
 rtl/rhd_seq_pkg.sv | 34 +++
 rtl/rhd_axil_wr_xact.sv | 104 ++++++++++
 rtl/rhd_acq_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_rhd_acq_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rhd_seq_pkg.sv
// ----------------------------------------------------------------------------
// rhd_seq_pkg
// Shared definitions for the RHD acquisition sequencer:
//   - seq_state_e   : sequencer FSM state encoding (also visible on dbg_state)
//   - REG_*         : register offsets inside the RHD acquisition peripheral
//   - AXI_RESP_OKAY : the only B response treated as success
//   - STOP_WORD     : control word that halts acquisition
//   - is_wr_state() : true for the states that own an AXI4-Lite write
// ----------------------------------------------------------------------------
package rhd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DELAY = 3'd1,
        ST_WR_PKT   = 3'd2,
        ST_WR_START = 3'd3,
        ST_RUN      = 3'd4,
        ST_WR_STOP  = 3'd5,
        ST_FINISH   = 3'd6
    } seq_state_e;

    localparam logic [7:0]  REG_CTRL      = 8'h00;
    localparam logic [7:0]  REG_DELAY     = 8'h04;
    localparam logic [7:0]  REG_PKT_LEN   = 8'h08;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [31:0] STOP_WORD     = 32'h0000_0000;

    function automatic logic is_wr_state(input seq_state_e s);
        return (s == ST_WR_DELAY) || (s == ST_WR_PKT) ||
               (s == ST_WR_START) || (s == ST_WR_STOP);
    endfunction

endpackage

// File: rtl/rhd_axil_wr_xact.sv
// ----------------------------------------------------------------------------
// rhd_axil_wr_xact
// Runs one AXI4-Lite single-beat write per req_i pulse.
//
// Handshake rule (all three channels): a transfer happens on the rising edge
// where VALID and READY are both high; a master VALID, once raised, stays high
// with stable payload until that edge, and READY may be raised or lowered
// freely by the receiver.  AW and W are retired independently; BREADY is only
// raised once both have been retired.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_i             one-cycle launch; captures addr_i/data_i
//   addr_i, data_i    write address / data for the launched transaction
//   kill_i            abandon the transaction in flight (drops all valids)
//   done_o            high in the cycle of the B handshake
//   resp_o            BRESP, meaningful while done_o is high
//   m_aw*, m_w*, m_b* AXI4-Lite write channels (WSTRB is implicitly 4'hF)
// ----------------------------------------------------------------------------
module rhd_axil_wr_xact #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    input  logic              kill_i,
    output logic              done_o,
    output logic [1:0]        resp_o,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

    logic              aw_pend_q;
    logic              w_pend_q;
    logic              aw_ok_q;
    logic              w_ok_q;
    logic              b_rdy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            b_rdy_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (req_i) begin
            // A launch always wins: the sequencer starts the next write on
            // the same edge that retires (or abandons) the previous one.
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            b_rdy_q   <= 1'b0;
            addr_q    <= addr_i;
            data_q    <= data_i;
        end else if (kill_i) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            b_rdy_q   <= 1'b0;
        end else begin
            if (aw_pend_q && m_awready) begin
                aw_pend_q <= 1'b0;
                aw_ok_q   <= 1'b1;
            end
            if (w_pend_q && m_wready) begin
                w_pend_q <= 1'b0;
                w_ok_q   <= 1'b1;
            end
            // BREADY rises the cycle after the later of the two handshakes.
            if (aw_ok_q && w_ok_q && !b_rdy_q) begin
                b_rdy_q <= 1'b1;
            end
            if (b_rdy_q && m_bvalid) begin
                b_rdy_q <= 1'b0;
                aw_ok_q <= 1'b0;
                w_ok_q  <= 1'b0;
            end
        end
    end

    assign m_awaddr  = addr_q;
    assign m_awvalid = aw_pend_q;
    assign m_wdata   = data_q;
    assign m_wvalid  = w_pend_q;
    assign m_bready  = b_rdy_q;
    assign done_o    = b_rdy_q & m_bvalid;
    assign resp_o    = m_bresp;

endmodule

// File: rtl/rhd_acq_sequencer.sv
// ----------------------------------------------------------------------------
// rhd_acq_sequencer
// Configures and runs one acquisition on the RHD peripheral over AXI4-Lite:
// write delay (0x4), packet length (0x8), start word (0x0), stay in RUN for
// run_cycles clocks, write the stop word (0x0), pulse done.
//
// Ports:
//   aclk, areset               clock, synchronous active-high reset
//   start                      request a run (only honoured in IDLE)
//   abort                      end the run early
//   cfg_delay, cfg_pkt_len     register values, captured on start
//   run_cycles                 acquisition length in aclk cycles, captured
//   m_aw*, m_w*, m_b*          AXI4-Lite write master
//   busy                       high whenever not IDLE
//   done                       one-cycle pulse in FINISH
//   error                      sticky failure flag, cleared by the next start
//   dbg_state                  current FSM state (seq_state_e encoding)
//
// Build option: define RHD_SEQ_TIMEOUT_EN to enable a per-write watchdog of
// TIMEOUT_CYCLES cycles; without it a write waits for BVALID indefinitely.
// ----------------------------------------------------------------------------
module rhd_acq_sequencer
    import rhd_seq_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter logic [31:0] START_WORD     = 32'h0000_0005,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       cfg_delay,
    input  logic [31:0]       cfg_pkt_len,
    input  logic [31:0]       run_cycles,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        dbg_state
);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [31:0]       pkt_q;
    logic [31:0]       run_q;
    logic [31:0]       cnt_q;
    logic              abort_pend_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic              launch;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              err_set;
    logic              to_hit;
    logic              x_done;
    logic [1:0]        x_resp;

    // ------------------------------------------------------------------
    // Next-state and write-launch decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        launch  = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WR_DELAY;
            end
            ST_WR_DELAY, ST_WR_PKT, ST_WR_START: begin
                if (to_hit) begin
                    err_set = 1'b1;
                    state_d = ST_WR_STOP;
                end else if (x_done) begin
                    if (x_resp != AXI_RESP_OKAY) begin
                        err_set = 1'b1;
                        state_d = ST_WR_STOP;
                    end else if (abort || abort_pend_q) begin
                        // An abort seen during this write takes effect only
                        // once the write has been answered.
                        state_d = ST_WR_STOP;
                    end else if (state_q == ST_WR_DELAY) begin
                        state_d = ST_WR_PKT;
                    end else if (state_q == ST_WR_PKT) begin
                        state_d = ST_WR_START;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // cnt_q <= 1 also covers run_cycles == 0 (one RUN cycle).
                if (abort || (cnt_q <= 32'd1)) state_d = ST_WR_STOP;
            end
            ST_WR_STOP: begin
                if (to_hit) begin
                    err_set = 1'b1;
                    state_d = ST_FINISH;
                end else if (x_done) begin
                    if (x_resp != AXI_RESP_OKAY) err_set = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A write is launched on the edge that enters its state, so the
        // valids are already up in the first cycle of that state.
        if ((state_d != state_q) && is_wr_state(state_d)) begin
            launch = 1'b1;
        end

        case (state_d)
            ST_WR_DELAY: begin
                // Launched only from IDLE, i.e. in the capture cycle itself,
                // so the live input is the captured value.
                wr_addr = ADDR_W'(REG_DELAY);
                wr_data = cfg_delay;
            end
            ST_WR_PKT: begin
                wr_addr = ADDR_W'(REG_PKT_LEN);
                wr_data = pkt_q;
            end
            ST_WR_START: begin
                wr_addr = ADDR_W'(REG_CTRL);
                wr_data = START_WORD;
            end
            ST_WR_STOP: begin
                wr_addr = ADDR_W'(REG_CTRL);
                wr_data = STOP_WORD;
            end
            default: begin
                wr_addr = '0;
                wr_data = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state, captured configuration and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            pkt_q        <= '0;
            run_q        <= '0;
            cnt_q        <= '0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_FINISH);

            if ((state_q == ST_IDLE) && start) begin
                pkt_q        <= cfg_pkt_len;
                run_q        <= run_cycles;
                error_q      <= 1'b0;
                abort_pend_q <= 1'b0;
            end else if (err_set) begin
                error_q <= 1'b1;
            end

            if (abort && ((state_q == ST_WR_DELAY) || (state_q == ST_WR_PKT) ||
                          (state_q == ST_WR_START))) begin
                abort_pend_q <= 1'b1;
            end

            if (state_d == ST_RUN) begin
                cnt_q <= (state_q == ST_RUN) ? (cnt_q - 32'd1) : run_q;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional B-response watchdog
    // ------------------------------------------------------------------
`ifdef RHD_SEQ_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            to_cnt_q <= '0;
        end else if ((state_d != state_q) || !is_wr_state(state_q)) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th cycle spent in a write state.
    assign to_hit = is_wr_state(state_q) && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign to_hit         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Single-write engine
    // ------------------------------------------------------------------
    rhd_axil_wr_xact #(
        .ADDR_W (ADDR_W)
    ) u_wr (
        .clk       (aclk),
        .rst       (areset),
        .req_i     (launch),
        .addr_i    (wr_addr),
        .data_i    (wr_data),
        .kill_i    (to_hit),
        .done_o    (x_done),
        .resp_o    (x_resp),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rhd_acq_sequencer.sv
`timescale 1ns/1ps
module tb_rhd_acq_sequencer;

    // ---------------- clock / reset ----------------
    logic        aclk = 1'b0;
    logic        areset;
    logic        start;
    logic        abort;
    logic [31:0] cfg_delay;
    logic [31:0] cfg_pkt_len;
    logic [31:0] run_cycles;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  dbg_state;

    always #5 aclk = ~aclk;

    rhd_acq_sequencer #(
        .ADDR_W         (32),
        .START_WORD     (32'h0000_0005),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .start       (start),
        .abort       (abort),
        .cfg_delay   (cfg_delay),
        .cfg_pkt_len (cfg_pkt_len),
        .run_cycles  (run_cycles),
        .m_awaddr    (m_awaddr),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];   // expected {addr, data} of each write, in order

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks (called on a negedge) ----------------
    task automatic kick(input logic [31:0] d, input logic [31:0] p, input logic [31:0] r);
        cfg_delay   = d;
        cfg_pkt_len = p;
        run_cycles  = r;
        start       = 1'b1;
        @(negedge aclk);
        start       = 1'b0;
    endtask

    // Peripheral side of one write: checks the next expected {addr,data},
    // waits for BREADY and answers with the given response.
    task automatic slave_write(input string tag, input logic [1:0] resp);
        logic [63:0] e;
        int n;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hdead_dead_dead_dead;
        n = 0;
        while (m_awvalid !== 1'b1 && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_aw_seen"}, 64'(n < 3000), 64'd1);
        chk({tag, "_addr_data"}, {m_awaddr, m_wdata}, e);
        n = 0;
        while (m_bready !== 1'b1 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_bready_seen"}, 64'(n < 50), 64'd1);
        m_bvalid = 1'b1;
        m_bresp  = resp;
        @(negedge aclk);
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        areset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_delay = '0; cfg_pkt_len = '0; run_cycles = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);

        // Reset state
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_flags", {busy, done, error}, 64'd0);
        chk("rst_valids", {m_awvalid, m_wvalid, m_bready}, 64'd0);
        chk("rst_addr_data", {m_awaddr, m_wdata}, 64'd0);

        // Normal run: 0x4/0, 0x8/8, 0x0/5, 100 RUN cycles, stop 0x0/0
        kick(32'd0, 32'd8, 32'd100);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_state", 64'(dbg_state), 64'd1);
        chk("t1_awvalid_first", {m_awvalid, m_wvalid}, 64'd3);
        exp_q.push_back({32'h4, 32'h0});
        exp_q.push_back({32'h8, 32'h8});
        exp_q.push_back({32'h0, 32'h5});
        slave_write("t1_delay", 2'b00);
        slave_write("t1_pkt", 2'b00);
        slave_write("t1_start", 2'b00);
        n = 0;
        while (m_awvalid !== 1'b1 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        chk("t1_run_len", 64'(n), 64'd100);
        exp_q.push_back({32'h0, 32'h0});
        slave_write("t1_stop", 2'b00);
        chk("t1_done", {done, error}, 64'b10);
        chk("t1_finish_state", 64'(dbg_state), 64'd6);
        @(negedge aclk);
        chk("t1_done_one_cycle", {done, busy}, 64'd0);

        // AW stalled 5 cycles while W accepts immediately
        m_awready = 1'b0;
        kick(32'd3, 32'd4, 32'd2);
        chk("t2_valids_first", {m_awvalid, m_wvalid}, 64'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("t2_aw_held", {m_awvalid, m_wvalid, m_bready, m_awaddr}, {3'b100, 32'h4});
        end
        m_awready = 1'b1;
        @(negedge aclk);
        chk("t2_aw_done_no_bready", {m_awvalid, m_bready}, 64'd0);
        @(negedge aclk);
        chk("t2_bready_up", 64'(m_bready), 64'd1);
        m_bvalid = 1'b1;
        @(negedge aclk);
        m_bvalid = 1'b0;
        exp_q.push_back({32'h8, 32'h4});
        exp_q.push_back({32'h0, 32'h5});
        exp_q.push_back({32'h0, 32'h0});
        slave_write("t2_pkt", 2'b00);
        slave_write("t2_start", 2'b00);
        slave_write("t2_stop", 2'b00);
        chk("t2_done", {done, error}, 64'b10);
        @(negedge aclk);

        // SLVERR on packet-length write: no start write, straight to stop
        kick(32'd1, 32'd2, 32'd50);
        exp_q.push_back({32'h4, 32'h1});
        exp_q.push_back({32'h8, 32'h2});
        exp_q.push_back({32'h0, 32'h0});
        slave_write("t3_delay", 2'b00);
        slave_write("t3_pkt", 2'b10);
        chk("t3_err_state", {error, dbg_state}, {1'b1, 3'd5});
        slave_write("t3_stop", 2'b00);
        chk("t3_done", {done, error}, 64'b11);
        @(negedge aclk);
        chk("t3_err_sticky", {busy, error}, 64'b01);

        // Abort at RUN cycle 10 of 1000; start pulse mid-run ignored
        kick(32'd0, 32'd0, 32'd1000);
        chk("t4_err_cleared", 64'(error), 64'd0);
        exp_q.push_back({32'h4, 32'h0});
        exp_q.push_back({32'h8, 32'h0});
        exp_q.push_back({32'h0, 32'h5});
        slave_write("t4_delay", 2'b00);
        slave_write("t4_pkt", 2'b00);
        slave_write("t4_start", 2'b00);
        repeat (4) @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("t4_start_ignored", {m_awvalid, dbg_state}, {1'b0, 3'd4});
        repeat (4) @(negedge aclk);
        chk("t4_still_run", 64'(dbg_state), 64'd4);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        chk("t4_stop_next", {m_awvalid, dbg_state, m_awaddr, m_wdata}, {1'b1, 3'd5, 64'd0});
        exp_q.push_back({32'h0, 32'h0});
        slave_write("t4_stop", 2'b00);
        chk("t4_done", {done, error}, 64'b10);
        @(negedge aclk);

        // Reset in WR_START with AWVALID up, then a full run
        kick(32'd5, 32'd6, 32'd3);
        exp_q.push_back({32'h4, 32'h5});
        exp_q.push_back({32'h8, 32'h6});
        slave_write("t5_delay", 2'b00);
        slave_write("t5_pkt", 2'b00);
        chk("t5_in_start", {m_awvalid, dbg_state}, {1'b1, 3'd3});
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        chk("t5_rst_valids", {m_awvalid, m_wvalid, m_bready}, 64'd0);
        chk("t5_rst_addr_data", {m_awaddr, m_wdata}, 64'd0);
        chk("t5_rst_flags", {busy, done, error, dbg_state}, 64'd0);
        kick(32'd5, 32'd6, 32'd3);
        exp_q.push_back({32'h4, 32'h5});
        exp_q.push_back({32'h8, 32'h6});
        exp_q.push_back({32'h0, 32'h5});
        exp_q.push_back({32'h0, 32'h0});
        slave_write("t5_delay2", 2'b00);
        slave_write("t5_pkt2", 2'b00);
        slave_write("t5_start2", 2'b00);
        slave_write("t5_stop2", 2'b00);
        chk("t5_done", {done, error}, 64'b10);
        @(negedge aclk);

`ifdef RHD_SEQ_TIMEOUT_EN
        // No BVALID on the delay write: error after 16 cycles, then stop
        kick(32'd7, 32'd7, 32'd7);
        chk("t6_first", {error, dbg_state}, {1'b0, 3'd1});
        repeat (15) @(negedge aclk);
        chk("t6_cycle16", {error, dbg_state}, {1'b0, 3'd1});
        @(negedge aclk);
        chk("t6_timeout", {error, dbg_state, m_awvalid, m_awaddr}, {1'b1, 3'd5, 1'b1, 32'h0});
        exp_q.push_back({32'h0, 32'h0});
        slave_write("t6_stop", 2'b00);
        chk("t6_done", {done, error}, 64'b11);
        @(negedge aclk);
`endif

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
